ppl_frame_sched: RTL
====================

Name: ppl_frame_sched

Overview:
- Frame-level scheduler for the ray-casting render path; one instance in the PPL clock domain.
- On each frame request it snapshots the player pose and issues every pixel address of an H_DISP x V_DISP frame to the ray pipeline with a valid/ready handshake.
- It counts returned samples from the map stage and signals frame completion.
- Map block edits are applied only between frames, so a frame never renders a half-edited world.

Parameters:
- H_DISP, 480, horizontal render resolution in pixels.
- V_DISP, 272, vertical render resolution in pixels; H_DISP*V_DISP must be at most 2^20.
- DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN after the last issue before the frame is force-completed.

Ports:
- clk  in  1  PPL clock.
- rst  in  1  asynchronous reset, active-high.
- frame_req  in  1  single-cycle pulse requesting a new frame (already synchronised to clk).
- in_pos_x / in_pos_y / in_pos_z  in  17 each  live player position.
- in_angle_x / in_angle_y  in  16 each  live player view angles.
- p_pos_x / p_pos_y / p_pos_z  out  17 each  pose latched for the current frame.
- p_angle_x / p_angle_y  out  16 each  angles latched for the current frame.
- pix_valid  out  1  pixel address valid.
- pix_addr  out  20  linear pixel address, y*H_DISP+x.
- pix_ready  in  1  pipeline accepts pix_addr.
- ret_valid  in  1  one returned sample from the map stage.
- edit_req  in  1  block edit request; held until acknowledged.
- edit_addr  in  15  block address of the edit.
- edit_data  in  5  new block id.
- edit_ack  out  1  edit accepted this cycle.
- write_en  out  1  map write strobe.
- write_addr  out  15  map write address.
- write_data  out  5  map write data.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle completion pulse.
- timeout_flag  out  1  sticky; set when a frame is force-completed.
- overrun_cnt  out  8  saturating count of dropped frame requests.

Behaviour:
- Reset values:
  - All outputs 0; pose registers 0.
  - State IDLE; pending flag 0; all counters 0.
- States: IDLE, EDIT, LATCH, ISSUE, DRAIN.
- IDLE:
  - frame_req or pending set -> LATCH; pending is cleared on this transition.
  - Otherwise, edit_req -> EDIT.
  - When frame_req and edit_req arrive together, the frame wins.
- EDIT (one cycle):
  - write_en=1, write_addr=edit_addr, write_data=edit_data, edit_ack=1.
  - -> IDLE. At most one edit per two cycles.
- LATCH (one cycle):
  - Registers all in_* into the p_* outputs.
  - Clears the issue counter and the return counter.
  - -> ISSUE.
  - p_* outputs hold their values until the next LATCH.
- ISSUE:
  - pix_valid=1 and pix_addr = issue counter.
  - pix_addr must hold stable while pix_valid=1 and pix_ready=0.
  - The counter increments on pix_valid&pix_ready.
  - The transfer at address H_DISP*V_DISP-1 -> DRAIN. pix_valid is 0 in DRAIN.
- Return counting:
  - ret_valid increments the return counter in ISSUE and DRAIN.
  - The counter saturates at H_DISP*V_DISP.
  - ret_valid in IDLE, EDIT or LATCH is ignored.
- DRAIN:
  - The return counter reaching H_DISP*V_DISP -> frame_done=1 for one cycle, -> IDLE.
  - Otherwise, DRAIN_TIMEOUT cycles spent in DRAIN -> frame_done=1, timeout_flag<=1, -> IDLE.
  - A return counted in the same cycle as the timeout completes the frame normally; timeout_flag is not set.
- Frame requests while busy:
  - frame_req when state is not IDLE sets pending if it is clear.
  - If pending is already set, the request increments overrun_cnt (saturates at 255) and is dropped.
- Edits while busy:
  - edit_req stays unacknowledged while busy. The requester holds it.
- Latency:
  - frame_req in IDLE -> LATCH next cycle.
  - First pix_valid two cycles after frame_req.
  - Back-to-back frames: IDLE lasts one cycle between frame_done and LATCH.
- Asynchronous reset mid-frame returns everything to reset values immediately.
  - Issue and return counters, pending and timeout_flag are cleared.
  - No partial write_en is emitted.

Test Plan:
- Full frame: H_DISP=4, V_DISP=2, pix_ready=1, ret_valid echoed 3 cycles after each transfer -> pix_addr 0..7 on consecutive cycles; frame_done on the cycle the 8th return is counted; busy=0 the next cycle.
- Backpressure: pix_ready toggles 1,0,0,1 -> each pix_addr held stable while stalled; no address skipped or repeated; exactly 8 transfers.
- Pose snapshot: in_pos_x=0x8000 at frame_req, changed to 0x1234 mid-frame -> p_pos_x stays 0x8000 until the next LATCH, then becomes 0x1234.
- Edit arbitration: edit_req (addr 0x0123, data 5) during ISSUE -> no write_en until after frame_done; then one cycle of write_en, write_addr=0x0123, write_data=5, edit_ack=1. A simultaneous frame_req and edit_req in IDLE -> LATCH first.
- Overrun: three frame_req pulses during ISSUE -> pending set; overrun_cnt=2; exactly one further frame starts after frame_done.
- Timeout and reset: no ret_valid, DRAIN_TIMEOUT=16 -> frame_done 16 cycles after entering DRAIN, timeout_flag=1. Asserting rst during ISSUE -> all outputs 0 within the same cycle; the next frame restarts at pix_addr 0.

Source files
------------

// File: rtl/ppl_frame_sched_if.sv
// Scheduler-side bundle: pose in/out, pixel issue handshake, sample returns and map edits.
// master = scheduler, slave = surrounding pipeline and requesters.
interface ppl_frame_sched_if;
    logic        frame_req;
    logic [16:0] in_pos_x;
    logic [16:0] in_pos_y;
    logic [16:0] in_pos_z;
    logic [15:0] in_angle_x;
    logic [15:0] in_angle_y;
    logic [16:0] p_pos_x;
    logic [16:0] p_pos_y;
    logic [16:0] p_pos_z;
    logic [15:0] p_angle_x;
    logic [15:0] p_angle_y;
    logic        pix_valid;
    logic [19:0] pix_addr;
    logic        pix_ready;
    logic        ret_valid;
    logic        edit_req;
    logic [14:0] edit_addr;
    logic [4:0]  edit_data;
    logic        edit_ack;
    logic        write_en;
    logic [14:0] write_addr;
    logic [4:0]  write_data;
    logic        busy;
    logic        frame_done;
    logic        timeout_flag;
    logic [7:0]  overrun_cnt;

    modport master (
        input  frame_req, in_pos_x, in_pos_y, in_pos_z, in_angle_x, in_angle_y,
               pix_ready, ret_valid, edit_req, edit_addr, edit_data,
        output p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y, pix_valid, pix_addr,
               edit_ack, write_en, write_addr, write_data, busy, frame_done,
               timeout_flag, overrun_cnt
    );

    modport slave (
        output frame_req, in_pos_x, in_pos_y, in_pos_z, in_angle_x, in_angle_y,
               pix_ready, ret_valid, edit_req, edit_addr, edit_data,
        input  p_pos_x, p_pos_y, p_pos_z, p_angle_x, p_angle_y, pix_valid, pix_addr,
               edit_ack, write_en, write_addr, write_data, busy, frame_done,
               timeout_flag, overrun_cnt
    );
endinterface

// File: rtl/ppl_frame_sched.sv
// Frame scheduler: snapshots the pose, issues every pixel address of a frame, counts
// returned samples and applies map edits only between frames.
module ppl_frame_sched #(
    parameter int unsigned H_DISP        = 480,
    parameter int unsigned V_DISP        = 272,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    ppl_frame_sched_if.master  bus
);
    localparam int unsigned NPIX = H_DISP * V_DISP;
    localparam int unsigned RW   = $clog2(NPIX + 1);
    localparam int unsigned DW   = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_EDIT, ST_LATCH, ST_ISSUE, ST_DRAIN
    } state_e;

    state_e        state_q;
    logic          pending_q;
    logic [RW-1:0] ret_cnt_q;
    logic [DW-1:0] drain_cnt_q;
    logic [16:0]   p_pos_x_q, p_pos_y_q, p_pos_z_q;
    logic [15:0]   p_angle_x_q, p_angle_y_q;
    logic          pix_valid_q;
    logic [19:0]   pix_addr_q;
    logic          edit_ack_q;
    logic          write_en_q;
    logic [14:0]   write_addr_q;
    logic [4:0]    write_data_q;
    logic          busy_q;
    logic          frame_done_q;
    logic          timeout_flag_q;
    logic [7:0]    overrun_cnt_q;

    logic in_frame_c;
    logic ret_last_c;

    assign in_frame_c = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    // The final sample either has already been counted or is being counted this cycle.
    assign ret_last_c = (ret_cnt_q == RW'(NPIX)) ||
                        (bus.ret_valid && (ret_cnt_q == RW'(NPIX - 1)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pending_q      <= 1'b0;
            ret_cnt_q      <= '0;
            drain_cnt_q    <= '0;
            p_pos_x_q      <= '0;
            p_pos_y_q      <= '0;
            p_pos_z_q      <= '0;
            p_angle_x_q    <= '0;
            p_angle_y_q    <= '0;
            pix_valid_q    <= 1'b0;
            pix_addr_q     <= '0;
            edit_ack_q     <= 1'b0;
            write_en_q     <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            timeout_flag_q <= 1'b0;
            overrun_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            edit_ack_q   <= 1'b0;
            write_en_q   <= 1'b0;

            // One request may wait behind the current frame; further ones are dropped.
            if ((state_q != ST_IDLE) && bus.frame_req) begin
                if (!pending_q) begin
                    pending_q <= 1'b1;
                end else if (overrun_cnt_q != 8'hFF) begin
                    overrun_cnt_q <= overrun_cnt_q + 8'd1;
                end
            end

            if (in_frame_c && bus.ret_valid && (ret_cnt_q != RW'(NPIX))) begin
                ret_cnt_q <= ret_cnt_q + RW'(1);
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_req || pending_q) begin
                        state_q   <= ST_LATCH;
                        pending_q <= 1'b0;
                        busy_q    <= 1'b1;
                    end else if (bus.edit_req) begin
                        state_q      <= ST_EDIT;
                        busy_q       <= 1'b1;
                        write_en_q   <= 1'b1;
                        edit_ack_q   <= 1'b1;
                        write_addr_q <= bus.edit_addr;
                        write_data_q <= bus.edit_data;
                    end
                end
                ST_EDIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                ST_LATCH: begin
                    p_pos_x_q   <= bus.in_pos_x;
                    p_pos_y_q   <= bus.in_pos_y;
                    p_pos_z_q   <= bus.in_pos_z;
                    p_angle_x_q <= bus.in_angle_x;
                    p_angle_y_q <= bus.in_angle_y;
                    pix_addr_q  <= '0;
                    ret_cnt_q   <= '0;
                    pix_valid_q <= 1'b1;
                    state_q     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (bus.pix_ready) begin
                        if (pix_addr_q == 20'(NPIX - 1)) begin
                            pix_valid_q <= 1'b0;
                            drain_cnt_q <= '0;
                            state_q     <= ST_DRAIN;
                        end else begin
                            pix_addr_q <= pix_addr_q + 20'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A normal completion takes priority over a coincident timeout.
                    if (ret_last_c) begin
                        frame_done_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end else if (drain_cnt_q == DW'(DRAIN_TIMEOUT - 1)) begin
                        frame_done_q   <= 1'b1;
                        timeout_flag_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= ST_IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p_pos_x      = p_pos_x_q;
    assign bus.p_pos_y      = p_pos_y_q;
    assign bus.p_pos_z      = p_pos_z_q;
    assign bus.p_angle_x    = p_angle_x_q;
    assign bus.p_angle_y    = p_angle_y_q;
    assign bus.pix_valid    = pix_valid_q;
    assign bus.pix_addr     = pix_addr_q;
    assign bus.edit_ack     = edit_ack_q;
    assign bus.write_en     = write_en_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_data   = write_data_q;
    assign bus.busy         = busy_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.timeout_flag = timeout_flag_q;
    assign bus.overrun_cnt  = overrun_cnt_q;
endmodule
